// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-N stream demultiplexer: mode encodings,
// drop counter width and a constant-evaluable clog2.
package demux_pkg;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

  localparam int DROP_CNT_W = 8;

  function automatic int clog2(input int value);
    int result;
    int one;
    result = 0;
    one    = 1;
    for (int i = 0; i < 31; i++) begin
      if ((one << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/demux_ch_reg_v.sv
// One-entry output register for a single demux channel; accepts a load while
// empty or while its current beat is being drained in the same cycle.
module demux_ch_reg_v #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_can_load
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_can_load = ~r_valid | i_ready;
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  // Load has priority over drain so a same-cycle drain+load keeps the entry full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

endmodule

// File: rtl/demux_1_n_stream_v.sv
// 1-to-N valid/ready stream demultiplexer with addressed and strict round-robin
// steering; illegal addressed selects are dropped and counted.
module demux_1_n_stream_v
  import demux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W-1:0]      i_data,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [N_CH-1:0]   o_valid,
  input  logic [N_CH-1:0]   i_ready,
  output logic [N_CH*W-1:0] o_data,
  output logic              o_err,
  output logic [DROP_CNT_W-1:0] o_drop_cnt
);

  localparam logic [SEL_W:0]   NCH_L   = (SEL_W + 1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0]      r_rr_ptr;
  logic                  r_err;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_rr_mode;
  logic [SEL_W-1:0]      w_target;
  logic                  w_illegal;
  logic                  w_tgt_open;
  logic                  w_accept;
  logic [N_CH-1:0]       w_can_load;
  logic [N_CH-1:0]       w_load;

  assign w_rr_mode = (mode_e'(i_mode) == MODE_RR);
  assign w_target  = w_rr_mode ? r_rr_ptr : i_sel;
  assign w_illegal = ~w_rr_mode & ({1'b0, i_sel} >= NCH_L);
  assign o_ready   = ~i_rst & (w_illegal | w_tgt_open);
  assign w_accept  = i_valid & o_ready;
  assign o_err      = r_err;
  assign o_drop_cnt = r_drop_cnt;

  // Steering: decode the target channel into its readiness and a load strobe.
  always_comb begin
    w_tgt_open = 1'b0;
    w_load     = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (w_target == SEL_W'(k)) begin
        w_tgt_open = w_can_load[k];
        w_load[k]  = i_valid & ~i_rst & ~w_illegal & w_can_load[k];
      end else begin
        w_load[k]  = 1'b0;
      end
    end
  end

  // Round-robin pointer advances only on accepted beats, so a stalled channel blocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr   <= '0;
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err <= w_accept & w_illegal;
      if (w_accept && w_illegal && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end else begin
        r_drop_cnt <= r_drop_cnt;
      end
      if (w_accept && w_rr_mode) begin
        r_rr_ptr <= (r_rr_ptr == LAST_CH) ? '0 : r_rr_ptr + SEL_W'(1);
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    demux_ch_reg_v #(.W(W)) u_ch (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load[k]),
      .i_data     (i_data),
      .i_ready    (i_ready[k]),
      .o_valid    (o_valid[k]),
      .o_data     (o_data[k*W +: W]),
      .o_can_load (w_can_load[k])
    );
  end

endmodule

// File: tb/tb_demux_1_n_stream_v.sv
// Bench for demux_1_n_stream_v: vector table plus per-channel scoreboard queues
// on a 4-channel instance, and an illegal-select run on a 3-channel instance.
module tb_demux_1_n_stream_v;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mode, valid, ready_o, err;
  logic [7:0]  data, dcnt;
  logic [1:0]  sel;
  logic [3:0]  ovalid, iready;
  logic [31:0] odata;

  logic        mode3, valid3, ready3, err3;
  logic [7:0]  data3, dcnt3;
  logic [1:0]  sel3;
  logic [2:0]  ovalid3, iready3;
  logic [23:0] odata3;

  demux_1_n_stream_v #(.N_CH(4), .W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_valid(valid), .o_ready(ready_o),
    .i_data(data), .i_sel(sel), .o_valid(ovalid), .i_ready(iready), .o_data(odata),
    .o_err(err), .o_drop_cnt(dcnt)
  );

  demux_1_n_stream_v #(.N_CH(3), .W(8)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_mode(mode3), .i_valid(valid3), .o_ready(ready3),
    .i_data(data3), .i_sel(sel3), .o_valid(ovalid3), .i_ready(iready3), .o_data(odata3),
    .o_err(err3), .o_drop_cnt(dcnt3)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int m_rr    = 0;
  logic [7:0] sb_q [4][$];
  logic [7:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every downstream transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (ovalid[k] && iready[k]) begin
          if (sb_q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_ch%0d: got 0x%0h, expected no beat", k, odata[k*8 +: 8]);
          end else begin
            mon_exp = sb_q[k].pop_front();
            chk($sformatf("sb_data_ch%0d", k), 32'(odata[k*8 +: 8]), 32'(mon_exp));
          end
        end
      end
    end
  end

  // Called at posedge+1; returns o_ready as seen mid-cycle and leaves time at next posedge+1.
  task automatic step(input logic md, input logic [1:0] s, input logic [7:0] d,
                      input logic v, input logic [3:0] rdy, output logic rdy_seen);
    int t;
    mode = md; sel = s; data = d; valid = v; iready = rdy;
    @(negedge clk);
    rdy_seen = ready_o;
    if (v && ready_o) begin
      t = md ? m_rr : int'(s);
      sb_q[t].push_back(d);
      if (md) m_rr = (m_rr + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       md;
    logic [1:0] s;
    logic [7:0] d;
    logic       exp_rdy;
    int         exp_ch;
  } vec_t;

  vec_t tv [15];
  logic r;
  int   n_err, ready_bad, v_bad;

  initial begin
    tv[0]  = '{1'b0, 2'd0, 8'hA1, 1'b1, 0};
    tv[1]  = '{1'b0, 2'd1, 8'hB2, 1'b1, 1};
    tv[2]  = '{1'b0, 2'd2, 8'hC3, 1'b1, 2};
    tv[3]  = '{1'b0, 2'd3, 8'hD4, 1'b1, 3};
    for (int i = 0; i < 8; i++) begin
      tv[4+i] = '{1'b1, 2'd3, 8'(8'h10 + i), 1'b1, i % 4};
    end
    tv[12] = '{1'b1, 2'd2, 8'h18, 1'b1, 0};
    tv[13] = '{1'b0, 2'd3, 8'h19, 1'b1, 3};
    tv[14] = '{1'b1, 2'd0, 8'h1A, 1'b1, 1};

    mode = 1'b0; valid = 1'b1; data = 8'h5A; sel = 2'd0; iready = 4'hF;
    mode3 = 1'b0; valid3 = 1'b0; data3 = 8'h00; sel3 = 2'd0; iready3 = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready_forced", ready_o, 1'b0);
    chk("rst_ovalid", ovalid, 4'h0);
    chk("rst_odata", odata, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_drop_cnt", dcnt, 8'h00);
    chk("rst_drop_cnt3", dcnt3, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    valid = 1'b0;

    // Addressed, round-robin (with wrap) and mode switches, all sinks ready.
    for (int i = 0; i < 15; i++) begin
      step(tv[i].md, tv[i].s, tv[i].d, 1'b1, 4'hF, r);
      chk($sformatf("vec%0d_ready", i), r, tv[i].exp_rdy);
      chk($sformatf("vec%0d_ovalid", i), ovalid, 32'(4'b0001 << tv[i].exp_ch));
      chk($sformatf("vec%0d_odata", i), odata[tv[i].exp_ch*8 +: 8], tv[i].d);
    end
    step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, r);
    chk("vec_drained", ovalid, 4'h0);

    // Backpressure on channel 2.
    step(1'b0, 2'd2, 8'h55, 1'b1, 4'b1011, r);
    chk("bp_ready_55", r, 1'b1);
    chk("bp_valid_55", ovalid[2], 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd2, 8'h66, 1'b1, 4'b1011, r);
      chk("bp_ready_66_stalled", r, 1'b0);
      chk("bp_hold_valid", ovalid[2], 1'b1);
      chk("bp_hold_data", odata[23:16], 8'h55);
    end
    step(1'b0, 2'd2, 8'h00, 1'b0, 4'b1011, r);
    chk("bp_ready_idle_stalled", r, 1'b0);
    step(1'b0, 2'd2, 8'h66, 1'b1, 4'b1111, r);
    chk("bp_ready_66_release", r, 1'b1);
    chk("bp_valid_66", ovalid[2], 1'b1);
    chk("bp_data_66", odata[23:16], 8'h66);
    step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, r);
    chk("bp_drained", ovalid, 4'h0);

    // Back-to-back drain and load on channel 1.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'd1, 8'(8'h21 + i), 1'b1, 4'hF, r);
      chk("dl_ready", r, 1'b1);
      chk("dl_valid", ovalid, 4'b0010);
      chk("dl_data", odata[15:8], 8'(8'h21 + i));
    end
    step(1'b0, 2'd0, 8'h00, 1'b0, 4'hF, r);
    chk("dl_drained", ovalid, 4'h0);
    chk("dl_queue_empty", sb_q[1].size(), 0);

    // Reset with three channels full, then round-robin restarts at channel 0.
    step(1'b1, 2'd0, 8'h31, 1'b1, 4'h0, r);
    step(1'b1, 2'd0, 8'h32, 1'b1, 4'h0, r);
    step(1'b1, 2'd0, 8'h33, 1'b1, 4'h0, r);
    chk("rstmid_full", ovalid, 4'b1101);
    rst = 1'b1;
    step(1'b1, 2'd0, 8'h40, 1'b1, 4'h0, r);
    chk("rstmid_ready_forced", r, 1'b0);
    chk("rstmid_ovalid", ovalid, 4'h0);
    chk("rstmid_odata", odata, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) sb_q[k].delete();
    m_rr = 0;
    step(1'b1, 2'd0, 8'h77, 1'b1, 4'h0, r);
    chk("rstmid_first_ready", r, 1'b1);
    chk("rstmid_first_ch0", ovalid, 4'b0001);
    chk("rstmid_first_data", odata[7:0], 8'h77);
    step(1'b1, 2'd0, 8'h00, 1'b0, 4'hF, r);
    step(1'b1, 2'd0, 8'h00, 1'b0, 4'hF, r);
    chk("rstmid_drained", ovalid, 4'h0);

    // Illegal select on the 3-channel instance.
    mode3 = 1'b0; sel3 = 2'd3; valid3 = 1'b1; iready3 = 3'b111; data3 = 8'hEE;
    n_err = 0; ready_bad = 0; v_bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready3 !== 1'b1) ready_bad++;
      @(posedge clk);
      #1;
      if (err3 === 1'b1) n_err++;
      if (ovalid3 !== 3'b000) v_bad++;
      if (i == 0) chk("ill_drop_cnt_first", dcnt3, 8'd1);
    end
    chk("ill_err_pulses", n_err, 300);
    chk("ill_ready_not_one", ready_bad, 0);
    chk("ill_valid_seen", v_bad, 0);
    chk("ill_drop_cnt_sat", dcnt3, 8'd255);
    sel3 = 2'd2; data3 = 8'h9C;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    chk("ill_err_ends", err3, 1'b0);
    chk("ill_legal_valid", ovalid3, 3'b100);
    chk("ill_legal_data", odata3[23:16], 8'h9C);
    chk("ill_drop_cnt_hold", dcnt3, 8'd255);

    for (int k = 0; k < 4; k++) begin
      chk($sformatf("final_queue_empty_ch%0d", k), sb_q[k].size(), 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
